// File: rtl/wide_imem_responder_pkg.sv
// Shared definitions for the wide instruction-memory responder family:
// FSM state encoding, word width and line-offset helper.
package wide_imem_responder_pkg;

  // Width of one memory word in bits.
  localparam int WORD_W = 32;

  // Responder FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_FILL  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Number of byte-offset bits inside one line of num_blocks 32-bit words.
  function automatic int line_off_w(input int num_blocks);
    return $clog2(num_blocks) + 2;
  endfunction

endpackage

// File: rtl/wide_imem_responder_if.sv
// Line-read request/response bus between an instruction cache (master)
// and the wide memory responder (slave).
interface wide_imem_responder_if #(
  parameter int NUM_BLOCKS = 4
);
  import wide_imem_responder_pkg::*;

  logic                         mem_req_valid;
  logic [31:0]                  mem_req_addr;
  logic                         mem_req_ready;
  logic [WORD_W*NUM_BLOCKS-1:0] mem_req_rdata;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_req_rdata
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_req_rdata
  );

endinterface

// File: rtl/imem_word_ram.sv
// Word-wide backing store: one synchronous write port, one asynchronous
// read port. Contents are never reset, so a loaded program survives reset.
// Because the read is combinational from the current array contents, a
// read and a write to the same word in one cycle return the old data.
module imem_word_ram
  import wide_imem_responder_pkg::*;
#(
  parameter int WORDS = 16384,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [WORDS];

  // Commit program-load writes on the rising edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wide_imem_responder.sv
// Wide instruction-memory responder. Accepts a line read from the cache,
// waits LATENCY cycles, streams NUM_BLOCKS words (one per cycle) out of the
// word RAM into a line register, pulses mem_req_ready for one cycle and then
// waits for the requester to drop valid before accepting the next request.
// Words are written through a separate load port usable in any state.
module wide_imem_responder
  import wide_imem_responder_pkg::*;
#(
  parameter int MEM_BYTES  = 65536,
  parameter int NUM_BLOCKS = 4,
  parameter int BLOCK_SIZE = 4,
  parameter int LATENCY    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  wide_imem_responder_if.slave        mem,
  input  logic                        load_en,
  input  logic [31:0]                 load_addr,
  input  logic [31:0]                 load_data,
  output logic                        busy,
  output logic [31:0]                 req_count
);

  localparam int WORDS  = MEM_BYTES / BLOCK_SIZE;
  localparam int AW     = $clog2(WORDS);
  localparam int WSH    = $clog2(BLOCK_SIZE);
  localparam int OFF_W  = line_off_w(NUM_BLOCKS);
  localparam int LINE_W = WORD_W * NUM_BLOCKS;
  localparam int IW     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;

  // Clears the word-within-line bits of a word index, giving the first
  // word of the line. Truncation to AW bits makes addresses alias modulo
  // the store size.
  localparam logic [AW-1:0] LINE_MASK = ~AW'((1 << (OFF_W - WSH)) - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [AW-1:0]       line_q, line_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic [31:0]         count_q, count_d;

  logic                ram_we;
  logic [AW-1:0]       ram_waddr;
  logic [AW-1:0]       ram_raddr;
  logic [WORD_W-1:0]   ram_rdata;

  // Address bits outside the word index (byte offset, high aliasing bits)
  // are intentionally ignored.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^{mem.mem_req_addr, load_addr};

  // Reset wins over a coincident load: the write is dropped.
  assign ram_we    = load_en & ~reset;
  assign ram_waddr = load_addr[AW+WSH-1:WSH];

  // Word index wraps naturally in AW bits.
  assign ram_raddr = line_q + AW'(idx_q);

  imem_word_ram #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (load_data),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // State, counters, line address, line data and completion count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: accept, wait, fill word by word, respond, drain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    count_d = count_q;

    unique case (state_q)
      ST_IDLE: begin
        // The request address is captured only here; later changes are ignored.
        if (mem.mem_req_valid) begin
          line_d = mem.mem_req_addr[AW+WSH-1:WSH] & LINE_MASK;
          idx_d  = '0;
          if (LATENCY == 0) begin
            state_d = ST_FILL;
          end else begin
            cnt_d   = CW'(LAT_M1);
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        // A withdrawn request aborts silently.
        if (!mem.mem_req_valid) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_FILL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_FILL: begin
        if (!mem.mem_req_valid) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          rdata_d[int'(idx_q)*WORD_W +: WORD_W] = ram_rdata;
          if (idx_q == IW'(NUM_BLOCKS - 1)) begin
            idx_d   = '0;
            state_d = ST_RESP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      ST_RESP: begin
        count_d = count_q + 32'd1;
        state_d = ST_DRAIN;
      end

      ST_DRAIN: begin
        // No new request is taken until the requester has released valid.
        if (!mem.mem_req_valid) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem.mem_req_ready = (state_q == ST_RESP);
  assign mem.mem_req_rdata = rdata_q;
  assign busy              = (state_q != ST_IDLE);
  assign req_count         = count_q;

endmodule

// File: tb/tb_wide_imem_responder.sv
// Bench for wide_imem_responder: a default build (LATENCY=2) and a
// LATENCY=0 build share clock, reset and load port. Requests push the
// expected line and ready cycle into a per-DUT queue; monitors pop and
// compare whenever mem_req_ready is seen.
module tb_wide_imem_responder;

  localparam int NB   = 4;
  localparam int MEMB = 65536;
  localparam int LW   = 32 * NB;

  localparam logic [31:0] A0 = 32'h1111_A000;
  localparam logic [31:0] A1 = 32'h2222_A001;
  localparam logic [31:0] A2 = 32'h3333_A002;
  localparam logic [31:0] A3 = 32'h4444_A003;
  localparam logic [31:0] B2 = 32'h5555_B002;
  localparam logic [31:0] JK = 32'hDEAD_BEEF;

  typedef struct {
    logic [LW-1:0] line;
    int            cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic [1:0]  valid;
  logic [31:0] addr [2];
  logic        busy0, busy1;
  logic [31:0] cnt0, cnt1;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];

  wide_imem_responder_if #(.NUM_BLOCKS(NB)) bus0 ();
  wide_imem_responder_if #(.NUM_BLOCKS(NB)) bus1 ();

  assign bus0.mem_req_valid = valid[0];
  assign bus0.mem_req_addr  = addr[0];
  assign bus1.mem_req_valid = valid[1];
  assign bus1.mem_req_addr  = addr[1];

  wide_imem_responder #(
    .MEM_BYTES(MEMB), .NUM_BLOCKS(NB), .BLOCK_SIZE(4), .LATENCY(2)
  ) dut0 (
    .clk(clk), .reset(reset), .mem(bus0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy0), .req_count(cnt0)
  );

  wide_imem_responder #(
    .MEM_BYTES(MEMB), .NUM_BLOCKS(NB), .BLOCK_SIZE(4), .LATENCY(0)
  ) dut1 (
    .clk(clk), .reset(reset), .mem(bus1),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy1), .req_count(cnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_ready(input int s);
    return (s == 0) ? bus0.mem_req_ready : bus1.mem_req_ready;
  endfunction

  function automatic logic get_busy(input int s);
    return (s == 0) ? busy0 : busy1;
  endfunction

  function automatic logic [31:0] get_cnt(input int s);
    return (s == 0) ? cnt0 : cnt1;
  endfunction

  function automatic logic [LW-1:0] get_rdata(input int s);
    return (s == 0) ? bus0.mem_req_rdata : bus1.mem_req_rdata;
  endfunction

  // Scoreboard monitor, default build.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (bus0.mem_req_ready === 1'b1) begin
      check("d0_ready_expected", LW'(q0.size() > 0), LW'(1'b1));
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("d0_rdata", bus0.mem_req_rdata, e.line);
        check("d0_ready_cycle", LW'(cyc), LW'(e.cyc));
      end
    end
  end

  // Scoreboard monitor, LATENCY=0 build.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (bus1.mem_req_ready === 1'b1) begin
      check("d1_ready_expected", LW'(q1.size() > 0), LW'(1'b1));
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("d1_rdata", bus1.mem_req_rdata, e.line);
        check("d1_ready_cycle", LW'(cyc), LW'(e.cyc));
      end
    end
  end

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One request on DUT s. Optional events (0 = none), numbered in cycles
  // after the IDLE cycle that samples valid: abort_at drops valid,
  // load_at pulses a load, rst_at pulses reset together with a load.
  task automatic do_req(input int s, input logic [31:0] a, input logic [LW-1:0] line,
                        input bit resp, input int hold, input int abort_at,
                        input int load_at, input int rst_at,
                        input logic [31:0] la, input logic [31:0] ld);
    int   e0, lat, rcyc;
    bit   done;
    exp_t e;
    lat  = (s == 0) ? 2 : 0;
    e0   = cyc;
    rcyc = -1;
    done = 1'b0;
    if (resp) begin
      e.line = line;
      e.cyc  = e0 + lat + NB + 1;
      if (s == 0) q0.push_back(e); else q1.push_back(e);
    end
    valid[s] = 1'b1;
    addr[s]  = a;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(posedge clk); #1;
      load_en = 1'b0;
      reset   = 1'b0;
      if (n == 1) addr[s] = ~a;
      if (abort_at > 0 && n == abort_at + 1) begin
        check("abort_idle", LW'(get_busy(s)), LW'(1'b0));
        check("abort_no_ready", LW'(get_ready(s)), LW'(1'b0));
        done = 1'b1;
      end else if (rst_at > 0 && n == rst_at + 1) begin
        check("rst_busy", LW'(get_busy(s)), LW'(1'b0));
        check("rst_no_ready", LW'(get_ready(s)), LW'(1'b0));
        check("rst_count", LW'(get_cnt(s)), LW'(0));
        check("rst_rdata", get_rdata(s), LW'(0));
        done = 1'b1;
      end else begin
        if (n == abort_at) valid[s] = 1'b0;
        if (n == rst_at) begin
          reset = 1'b1; valid[s] = 1'b0;
          load_en = 1'b1; load_addr = la; load_data = ld;
        end
        if (n == load_at) begin
          load_en = 1'b1; load_addr = la; load_data = ld;
        end
        if (get_ready(s) && rcyc < 0) rcyc = n;
        if (rcyc > 0 && n == rcyc + hold + 1) begin
          check("drain_busy", LW'(get_busy(s)), LW'(1'b1));
          valid[s] = 1'b0;
        end
        if (rcyc > 0 && n == rcyc + hold + 2) begin
          check("idle_after_drop", LW'(get_busy(s)), LW'(1'b0));
          done = 1'b1;
        end
      end
    end
    check("req_done", LW'(done), LW'(1'b1));
    valid[s] = 1'b0;
    load_en  = 1'b0;
    reset    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    valid     = 2'b00;
    addr[0]   = '0;
    addr[1]   = '0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready0", LW'(bus0.mem_req_ready), LW'(1'b0));
    check("reset_busy0",  LW'(busy0), LW'(1'b0));
    check("reset_count0", LW'(cnt0), LW'(0));
    check("reset_rdata0", bus0.mem_req_rdata, LW'(0));
    check("reset_ready1", LW'(bus1.mem_req_ready), LW'(1'b0));
    check("reset_busy1",  LW'(busy1), LW'(1'b0));
    check("reset_count1", LW'(cnt1), LW'(0));
    check("reset_rdata1", bus1.mem_req_rdata, LW'(0));
    reset = 1'b0;

    load_word(32'h100, A0);
    load_word(32'h104, A1);
    load_word(32'h108, A2);
    load_word(32'h10C, A3);
    idle(1);

    // Basic line read with valid held three cycles past ready.
    do_req(0, 32'h104, {A3, A2, A1, A0}, 1'b1, 3, 0, 0, 0, 32'h0, 32'h0);
    check("count_after_t1", LW'(cnt0), LW'(1));
    idle(1);

    // Abort in the second FILL cycle.
    do_req(0, 32'h100, '0, 1'b0, 1, 4, 0, 0, 32'h0, 32'h0);
    check("count_after_abort", LW'(cnt0), LW'(1));

    // Recovery request, offset inside the same line.
    do_req(0, 32'h108, {A3, A2, A1, A0}, 1'b1, 1, 0, 0, 0, 32'h0, 32'h0);
    check("count_after_t3", LW'(cnt0), LW'(2));
    idle(1);

    // Address beyond the store aliases onto 0x100.
    do_req(0, MEMB + 32'h100, {A3, A2, A1, A0}, 1'b1, 1, 0, 0, 0, 32'h0, 32'h0);
    check("count_after_wrap", LW'(cnt0), LW'(3));
    idle(1);

    // Load of word 0x108 in the FILL cycle that reads it returns old data.
    do_req(0, 32'h100, {A3, A2, A1, A0}, 1'b1, 1, 0, 5, 0, 32'h108, B2);
    check("count_after_rbw", LW'(cnt0), LW'(4));
    idle(1);

    do_req(0, 32'h10C, {A3, B2, A1, A0}, 1'b1, 1, 0, 0, 0, 32'h0, 32'h0);
    check("count_after_newdata", LW'(cnt0), LW'(5));
    idle(1);

    // Reset in WAIT with a coincident load that must be dropped.
    do_req(0, 32'h100, '0, 1'b0, 1, 0, 0, 1, 32'h10C, JK);
    idle(1);

    // Memory survives reset; the dropped write left 0x10C unchanged.
    do_req(0, 32'h100, {A3, B2, A1, A0}, 1'b1, 1, 0, 0, 0, 32'h0, 32'h0);
    check("count_after_reset_req", LW'(cnt0), LW'(1));
    idle(1);

    // LATENCY=0 build: ready five cycles after acceptance.
    do_req(1, 32'h104, {A3, B2, A1, A0}, 1'b1, 1, 0, 0, 0, 32'h0, 32'h0);
    check("count_lat0", LW'(cnt1), LW'(1));
    idle(3);

    check("rdata_hold0", bus0.mem_req_rdata, {A3, B2, A1, A0});
    check("rdata_hold1", bus1.mem_req_rdata, {A3, B2, A1, A0});
    check("sb_empty0", LW'(q0.size()), LW'(0));
    check("sb_empty1", LW'(q1.size()), LW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wide_imem_responder.md
WIDE_IMEM_RESPONDER -- requirements
Module: wide_imem_responder

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 65536, meaning backing store size in bytes (power of two).
REQ-002 The block SHALL have parameter NUM_BLOCKS, default 4, meaning 32-bit words per returned line (power of two).
REQ-003 The block SHALL have parameter BLOCK_SIZE, default 4, meaning bytes per word; only 4 is supported.
REQ-004 The block SHALL have parameter LATENCY, default 2, meaning access delay in cycles before the line fill starts (0 allowed).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 mem_req_valid  input  1  line read request from the cache; held high until one cycle after ready.
REQ-008 mem_req_addr  input  32  line byte address; low log2(NUM_BLOCKS)+2 bits ignored.
REQ-009 mem_req_ready  output  1  one-cycle pulse; line data valid on mem_req_rdata.
REQ-010 mem_req_rdata  output  32*NUM_BLOCKS  returned line; word k at bits [32k+31:32k].
REQ-011 load_en  input  1  word write strobe for program loading.
REQ-012 load_addr  input  32  byte address of the word written; low 2 bits ignored.
REQ-013 load_data  input  32  word written.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 req_count  output  32  number of completed line responses.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, FILL, RESP and DRAIN.
REQ-017 In IDLE with mem_req_valid high, the block SHALL latch the line address (addr with offset bits cleared) and go to WAIT, or to FILL if LATENCY=0.
REQ-018 WAIT SHALL last exactly LATENCY cycles, counted by a down-counter, then go to FILL.
REQ-019 FILL SHALL read one word per cycle from word index (line address/4 + k) for k=0..NUM_BLOCKS-1, writing word k into its rdata slice, then go to RESP.
REQ-020 Word addresses SHALL wrap modulo MEM_BYTES/4; out-of-range addresses alias and never raise an error.
REQ-021 RESP SHALL last one cycle with mem_req_ready=1, increment req_count by 1 (wrapping at 2^32) and go to DRAIN.
REQ-022 mem_req_ready SHALL be high in no state other than RESP.
REQ-023 DRAIN SHALL remain until mem_req_valid is sampled low, then go to IDLE; a new request is never accepted in DRAIN.
REQ-024 First ready SHALL occur LATENCY+NUM_BLOCKS+1 cycles after the IDLE cycle that sampled valid high (7 at defaults).
REQ-025 mem_req_rdata SHALL hold its value from RESP until the next FILL writes it.
REQ-026 If mem_req_valid is low in WAIT or FILL, the block SHALL abort to IDLE without ready and without incrementing req_count.
REQ-027 A load_en write SHALL be accepted in any state and commit on the same edge.
REQ-028 A same-cycle FILL read of the word being written SHALL return the old data (read-before-write).
REQ-029 mem_req_addr SHALL be sampled only in IDLE; changes during later states SHALL be ignored.

Reset
REQ-030 On reset the block SHALL enter IDLE with mem_req_ready=0, busy=0, req_count=0, mem_req_rdata=0 and the latency counter at 0.
REQ-031 Reset in any state SHALL abandon the transaction with no ready pulse and SHALL NOT clear memory contents.
REQ-032 Reset SHALL have priority over load_en on the same edge; that write SHALL be dropped.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the word width (32) and the line-offset width function, for reuse by the icache variants.
REQ-034 The word store SHALL be the sub-module imem_word_ram (one synchronous write port, one asynchronous read port, MEM_BYTES/4 words).
REQ-035 The ram contents SHALL NOT be reset.

Verification
REQ-036 Load words 0x100..0x10C = A0,A1,A2,A3; request 0x104 at defaults -> ready at cycle 7; rdata={A3,A2,A1,A0}; req_count=1.
REQ-037 Hold valid 3 cycles after ready -> single ready pulse; DRAIN held; IDLE one cycle after valid drops.
REQ-038 Drop valid in the 2nd FILL cycle -> no ready; IDLE next cycle; req_count unchanged; new request then completes normally.
REQ-039 Request MEM_BYTES+0x100 -> same data as 0x100 (wrap).
REQ-040 load_en to word 0x108 in the FILL cycle reading it -> old value returned; next request returns new value.
REQ-041 Assert reset during WAIT -> ready never pulses; busy=0; memory preserved; LATENCY=0 build returns ready at cycle 5.
